// File: rtl/addr_rule_loader.sv
// Loads address-range comparator rules over a 64-bit cfg write port.
// Rules are disabled before base/flags change and re-enabled last, so no transient false match occurs.
module addr_rule_loader #(
  parameter int NUM_RULES      = 32,
  parameter int NUM_RULES_LOG2 = 5,
  parameter int FLAG_WIDTH     = 32,
  parameter int CFG_WIDTH      = 10,
  parameter int INIT_CLEAR     = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [1:0]                desc_op,
  input  logic [NUM_RULES_LOG2-1:0] desc_index,
  input  logic [63:0]               desc_base,
  input  logic [63:0]               desc_size,
  input  logic [FLAG_WIDTH-1:0]     desc_flags,
  output logic [CFG_WIDTH-1:0]      cfg_address,
  output logic                      cfg_write,
  output logic [63:0]               cfg_writedata,
  output logic [7:0]                cfg_byteenable,
  output logic [NUM_RULES-1:0]      rule_live,
  output logic                      busy,
  output logic                      desc_err,
  output logic [7:0]                err_count
);

  typedef enum logic [2:0] {
    INIT_SWEEP, IDLE, W_DIS, W_BASE, W_FLAGS, W_SIZE, SWEEP, ERR
  } state_t;

  localparam logic [1:0] OP_PROGRAM    = 2'd0;
  localparam logic [1:0] OP_CLEAR_RULE = 2'd1;
  localparam logic [1:0] OP_SET_DSM    = 2'd2;
  localparam logic [1:0] OP_CLEAR_ALL  = 2'd3;

  localparam logic [CFG_WIDTH-1:0]      SIZE_OFF = CFG_WIDTH'(NUM_RULES);
  localparam logic [CFG_WIDTH-1:0]      FLAG_OFF = CFG_WIDTH'(2 * NUM_RULES);
  localparam logic [CFG_WIDTH-1:0]      DSM_ADDR = CFG_WIDTH'(3 * NUM_RULES);
  localparam logic [NUM_RULES_LOG2-1:0] LAST_IDX = NUM_RULES_LOG2'(NUM_RULES - 1);
  localparam logic                      INIT_ON  = (INIT_CLEAR != 0);

  state_t                      state_reg, state_next;
  logic                        init_pending_reg;
  logic [1:0]                  op_reg;
  logic [NUM_RULES_LOG2-1:0]   index_reg;
  logic [63:0]                 base_reg;
  logic [63:0]                 size_reg;
  logic [FLAG_WIDTH-1:0]       flags_reg;
  logic [NUM_RULES_LOG2-1:0]   sweep_idx_reg, sweep_idx_next;

  logic                        accept;
  logic                        index_bad;
  logic                        addr_wrap;
  logic [1:0]                  in_op;
  logic                        reject;
  logic [1:0]                  cur_op;
  logic [NUM_RULES_LOG2-1:0]   cur_index;
  logic [63:0]                 cur_base;
  logic [63:0]                 cur_size;
  logic [FLAG_WIDTH-1:0]       cur_flags;

  logic                        desc_ready_next;
  logic                        cfg_write_next;
  logic [CFG_WIDTH-1:0]        cfg_address_next;
  logic [63:0]                 cfg_writedata_next;
  logic [NUM_RULES-1:0]        rule_live_next;
  logic                        busy_next;
  logic                        desc_err_next;
  logic [7:0]                  err_count_next;

  always_comb begin
    accept    = desc_ready && desc_valid;
    index_bad = (32'(desc_index) >= 32'(NUM_RULES));
    // base+size carries out of 64 bits exactly when size exceeds 2^64-1-base
    addr_wrap = (desc_size > ~desc_base);
    in_op     = (desc_op == OP_PROGRAM && desc_size == 64'd0) ? OP_CLEAR_RULE : desc_op;
    reject    = ((in_op == OP_PROGRAM) && (index_bad || addr_wrap)) ||
                ((in_op == OP_CLEAR_RULE) && index_bad);
    cur_op    = accept ? in_op      : op_reg;
    cur_index = accept ? desc_index : index_reg;
    cur_base  = accept ? desc_base  : base_reg;
    cur_size  = accept ? desc_size  : size_reg;
    cur_flags = accept ? desc_flags : flags_reg;
  end

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      IDLE: begin
        if (init_pending_reg) begin
          state_next     = INIT_SWEEP;
          sweep_idx_next = '0;
        end else if (accept) begin
          if (reject) begin
            state_next = ERR;
          end else begin
            case (in_op)
              OP_PROGRAM, OP_CLEAR_RULE: state_next = W_DIS;
              OP_SET_DSM:                state_next = W_BASE;
              default: begin
                state_next     = SWEEP;
                sweep_idx_next = '0;
              end
            endcase
          end
        end
      end
      W_DIS:   state_next = (op_reg == OP_PROGRAM) ? W_BASE : IDLE;
      W_BASE:  state_next = (op_reg == OP_SET_DSM) ? IDLE : W_FLAGS;
      W_FLAGS: state_next = W_SIZE;
      W_SIZE:  state_next = IDLE;
      ERR:     state_next = IDLE;
      INIT_SWEEP, SWEEP: begin
        if (sweep_idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          sweep_idx_next = sweep_idx_reg + NUM_RULES_LOG2'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the state being entered, so they line up with it.
    desc_ready_next    = (state_next == IDLE);
    busy_next          = (state_next != IDLE);
    cfg_write_next     = 1'b0;
    cfg_address_next   = '0;
    cfg_writedata_next = '0;
    rule_live_next     = rule_live;
    desc_err_next      = 1'b0;
    err_count_next     = err_count;
    case (state_next)
      W_DIS: begin
        cfg_write_next   = 1'b1;
        cfg_address_next = SIZE_OFF + CFG_WIDTH'(cur_index);
        for (int i = 0; i < NUM_RULES; i++) begin
          if (cur_index == NUM_RULES_LOG2'(i)) rule_live_next[i] = 1'b0;
        end
      end
      W_BASE: begin
        cfg_write_next     = 1'b1;
        cfg_address_next   = (cur_op == OP_SET_DSM) ? DSM_ADDR : CFG_WIDTH'(cur_index);
        cfg_writedata_next = cur_base;
      end
      W_FLAGS: begin
        cfg_write_next     = 1'b1;
        cfg_address_next   = FLAG_OFF + CFG_WIDTH'(cur_index);
        cfg_writedata_next = 64'(cur_flags);
      end
      W_SIZE: begin
        cfg_write_next     = 1'b1;
        cfg_address_next   = SIZE_OFF + CFG_WIDTH'(cur_index);
        cfg_writedata_next = cur_size;
        for (int i = 0; i < NUM_RULES; i++) begin
          if (cur_index == NUM_RULES_LOG2'(i)) rule_live_next[i] = 1'b1;
        end
      end
      INIT_SWEEP, SWEEP: begin
        cfg_write_next   = 1'b1;
        cfg_address_next = SIZE_OFF + CFG_WIDTH'(sweep_idx_next);
        if (sweep_idx_next == LAST_IDX) rule_live_next = '0;
      end
      ERR: begin
        desc_err_next = 1'b1;
        if (err_count != 8'hFF) err_count_next = err_count + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      init_pending_reg <= INIT_ON;
      op_reg           <= OP_PROGRAM;
      index_reg        <= '0;
      base_reg         <= '0;
      size_reg         <= '0;
      flags_reg        <= '0;
      sweep_idx_reg    <= '0;
      desc_ready       <= 1'b0;
      cfg_write        <= 1'b0;
      cfg_address      <= '0;
      cfg_writedata    <= '0;
      cfg_byteenable   <= '0;
      rule_live        <= '0;
      busy             <= 1'b0;
      desc_err         <= 1'b0;
      err_count        <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
      if (state_reg == IDLE) init_pending_reg <= 1'b0;
      if (accept) begin
        op_reg    <= in_op;
        index_reg <= desc_index;
        base_reg  <= desc_base;
        size_reg  <= desc_size;
        flags_reg <= desc_flags;
      end
      desc_ready     <= desc_ready_next;
      cfg_write      <= cfg_write_next;
      cfg_address    <= cfg_address_next;
      cfg_writedata  <= cfg_writedata_next;
      cfg_byteenable <= cfg_write_next ? 8'hFF : 8'h00;
      rule_live      <= rule_live_next;
      busy           <= busy_next;
      desc_err       <= desc_err_next;
      err_count      <= err_count_next;
    end
  end

endmodule

// File: tb/tb_addr_rule_loader.sv
// Scoreboarded bench for addr_rule_loader: expected cfg writes are queued as
// descriptors are driven and popped by a monitor as the DUT writes them.
module tb_addr_rule_loader;

  localparam int NR = 32;
  localparam int NL = 6;   // wide enough to express out-of-range index 32

  logic          clk;
  logic          reset_n;
  logic          desc_valid;
  logic          desc_ready;
  logic [1:0]    desc_op;
  logic [NL-1:0] desc_index;
  logic [63:0]   desc_base;
  logic [63:0]   desc_size;
  logic [31:0]   desc_flags;
  logic [9:0]    cfg_address;
  logic          cfg_write;
  logic [63:0]   cfg_writedata;
  logic [7:0]    cfg_byteenable;
  logic [NR-1:0] rule_live;
  logic          busy;
  logic          desc_err;
  logic [7:0]    err_count;

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic [NR-1:0] exp_live = '0;

  addr_rule_loader #(
    .NUM_RULES(NR), .NUM_RULES_LOG2(NL), .FLAG_WIDTH(32), .CFG_WIDTH(10), .INIT_CLEAR(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_op(desc_op),
    .desc_index(desc_index), .desc_base(desc_base), .desc_size(desc_size),
    .desc_flags(desc_flags),
    .cfg_address(cfg_address), .cfg_write(cfg_write), .cfg_writedata(cfg_writedata),
    .cfg_byteenable(cfg_byteenable),
    .rule_live(rule_live), .busy(busy), .desc_err(desc_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cfg write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && cfg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%h, required no write", cfg_address, cfg_writedata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (cfg_address !== e.addr || cfg_writedata !== e.data || cfg_byteenable !== 8'hFF) begin
          errors++;
          $display("FAIL cfg_write: got addr=%0d data=0x%h be=%h, required addr=%0d data=0x%h be=ff",
                   cfg_address, cfg_writedata, cfg_byteenable, e.addr, e.data);
        end else begin
          $display("write ok: addr=%0d data=0x%h", cfg_address, cfg_writedata);
        end
      end
    end
  end

  task automatic push_wr(input int addr, input logic [63:0] data);
    wr_t e;
    e.addr = 10'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input int idx, input logic [63:0] base, input logic [63:0] size,
                           input logic [31:0] flags);
    push_wr(NR + idx, 64'd0);
    push_wr(idx, base);
    push_wr(2 * NR + idx, {32'd0, flags});
    push_wr(NR + idx, size);
  endtask

  task automatic push_sweep();
    for (int k = 0; k < NR; k++) push_wr(NR + k, 64'd0);
  endtask

  // Returns #1 after the handshake edge T.
  task automatic send(input logic [1:0] op, input int idx, input logic [63:0] base,
                      input logic [63:0] size, input logic [31:0] flags);
    int n;
    @(negedge clk);
    desc_op = op; desc_index = NL'(idx); desc_base = base; desc_size = size; desc_flags = flags;
    desc_valid = 1'b1;
    n = 0;
    while (desc_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: desc_ready=%b, required 1 within 200 cycles", desc_ready);
    end
    @(posedge clk);
    #1 desc_valid = 1'b0;
    $display("descriptor sent: op=%0d index=%0d base=0x%h size=0x%h", op, idx, base, size);
  endtask

  task automatic test_reset();
    bit ok;
    reset_n = 1'b0;
    desc_valid = 1'b0; desc_op = '0; desc_index = '0; desc_base = '0; desc_size = '0; desc_flags = '0;
    #3;
    checks++;
    if (desc_ready !== 1'b0 || cfg_write !== 1'b0 || busy !== 1'b0 || rule_live !== '0 ||
        err_count !== 8'd0 || desc_err !== 1'b0 || cfg_byteenable !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: ready=%b write=%b busy=%b live=%h errc=%0d, required all 0",
               desc_ready, cfg_write, busy, rule_live, err_count);
    end
    push_sweep();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < NR; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cfg_write !== 1'b1 || desc_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_sweep_busy: busy/write not held for %0d cycles, required 1", NR);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || desc_ready !== 1'b1 || rule_live !== '0 || cfg_write !== 1'b0) begin
      errors++;
      $display("FAIL init_sweep_end: busy=%b ready=%b live=%h, required 0 1 0", busy, desc_ready, rule_live);
    end
  endtask

  task automatic test_program();
    bit ok;
    push_prog(3, 64'h1000, 64'h200, 32'h5);
    send(2'd0, 3, 64'h1000, 64'h200, 32'h5);
    exp_live[3] = 1'b1;
    ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (cfg_write !== 1'b1 || busy !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL program_writes: write gap in T+1..T+4, required 4 back-to-back writes"); end
    checks++;
    if (rule_live !== exp_live) begin
      errors++; $display("FAIL program_live: rule_live=%h, required %h", rule_live, exp_live);
    end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || cfg_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL program_idle: ready=%b write=%b busy=%b at T+5, required 1 0 0", desc_ready, cfg_write, busy);
    end
  endtask

  task automatic test_reject();
    send(2'd0, 0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 32'h0);
    @(negedge clk);
    checks++;
    if (desc_err !== 1'b1 || cfg_write !== 1'b0 || err_count !== 8'd1) begin
      errors++; $display("FAIL reject_wrap: err=%b write=%b count=%0d, required 1 0 1", desc_err, cfg_write, err_count);
    end
    @(negedge clk);
    checks++;
    if (desc_err !== 1'b0 || desc_ready !== 1'b1) begin
      errors++; $display("FAIL reject_wrap_idle: err=%b ready=%b, required 0 1", desc_err, desc_ready);
    end
    send(2'd0, 32, 64'h0, 64'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (desc_err !== 1'b1 || cfg_write !== 1'b0 || err_count !== 8'd2) begin
      errors++; $display("FAIL reject_index: err=%b write=%b count=%0d, required 1 0 2", desc_err, cfg_write, err_count);
    end
    // End address 2^64-1 is legal.
    push_prog(4, 64'hFFFF_FFFF_FFFF_F000, 64'hFFF, 32'h1);
    send(2'd0, 4, 64'hFFFF_FFFF_FFFF_F000, 64'hFFF, 32'h1);
    exp_live[4] = 1'b1;
    @(negedge clk);
    checks++;
    if (desc_err !== 1'b0 || cfg_write !== 1'b1 || err_count !== 8'd2) begin
      errors++; $display("FAIL accept_top_edge: err=%b write=%b count=%0d, required 0 1 2", desc_err, cfg_write, err_count);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rule_live !== exp_live || desc_ready !== 1'b1) begin
      errors++; $display("FAIL accept_top_live: live=%h ready=%b, required %h 1", rule_live, desc_ready, exp_live);
    end
  endtask

  task automatic test_dsm_clear();
    push_wr(3 * NR, 64'hABCD_0000);
    send(2'd2, 0, 64'hABCD_0000, 64'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (cfg_write !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL dsm_write: write=%b busy=%b at T+1, required 1 1", cfg_write, busy);
    end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || cfg_write !== 1'b0) begin
      errors++; $display("FAIL dsm_idle: ready=%b write=%b at T+2, required 1 0", desc_ready, cfg_write);
    end
    push_wr(NR + 3, 64'd0);
    send(2'd1, 3, 64'h0, 64'h0, 32'h0);
    exp_live[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (rule_live !== exp_live || cfg_write !== 1'b1) begin
      errors++; $display("FAIL clear_rule: live=%h write=%b, required %h 1", rule_live, cfg_write, exp_live);
    end
    // PROGRAM with zero size behaves as CLEAR_RULE.
    push_wr(NR + 4, 64'd0);
    send(2'd0, 4, 64'h7000, 64'h0, 32'h9);
    exp_live[4] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rule_live !== exp_live || desc_ready !== 1'b1 || cfg_write !== 1'b0) begin
      errors++; $display("FAIL program_size0: live=%h ready=%b write=%b, required %h 1 0", rule_live, desc_ready, cfg_write, exp_live);
    end
  endtask

  task automatic test_clear_all();
    bit ok;
    push_prog(7, 64'h8000, 64'h40, 32'h2);
    send(2'd0, 7, 64'h8000, 64'h40, 32'h2);
    exp_live[7] = 1'b1;
    repeat (4) @(negedge clk);
    push_sweep();
    send(2'd3, 0, 64'h0, 64'h0, 32'h0);
    ok = 1'b1;
    for (int c = 1; c < NR; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cfg_write !== 1'b1 || rule_live !== exp_live) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL clear_all_run: busy/write/live wrong before final write, required live=%h", exp_live); end
    exp_live = '0;
    @(negedge clk);
    checks++;
    if (rule_live !== exp_live || cfg_write !== 1'b1) begin
      errors++; $display("FAIL clear_all_final: live=%h write=%b, required 0 1", rule_live, cfg_write);
    end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_all_idle: ready=%b busy=%b, required 1 0", desc_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    push_wr(NR + 5, 64'd0);
    push_wr(5, 64'h5000);
    send(2'd0, 5, 64'h5000, 64'h100, 32'h3);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cfg_write !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b0 || rule_live !== '0 || err_count !== 8'd0) begin
      errors++; $display("FAIL reset_mid: write=%b busy=%b ready=%b live=%h errc=%0d, required all 0",
                         cfg_write, busy, desc_ready, rule_live, err_count);
    end
    exp_live = '0;
    push_sweep();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < NR; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cfg_write !== 1'b1 || desc_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL resweep_busy: sweep not %0d busy write cycles after reset", NR); end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL resweep_end: ready=%b busy=%b, required 1 0", desc_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    push_prog(1, 64'h100, 64'h10, 32'hA);
    push_prog(2, 64'h200, 64'h20, 32'hB);
    @(negedge clk);
    desc_op = 2'd0; desc_index = NL'(1); desc_base = 64'h100; desc_size = 64'h10; desc_flags = 32'hA;
    desc_valid = 1'b1;
    n = 0;
    while (desc_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    desc_index = NL'(2); desc_base = 64'h200; desc_size = 64'h20; desc_flags = 32'hB;
    ok = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (desc_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || n >= 200) begin errors++; $display("FAIL b2b_ready_low: desc_ready high while busy, required 0 for T+1..T+4"); end
    @(negedge clk);
    checks++;
    if (desc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t5: desc_ready=%b at T+5, required 1", desc_ready); end
    @(posedge clk);
    #1 desc_valid = 1'b0;
    exp_live[1] = 1'b1; exp_live[2] = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rule_live !== exp_live || desc_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_live: live=%h ready=%b, required %h 1", rule_live, desc_ready, exp_live);
    end
  endtask

  task automatic test_err_saturate();
    int n;
    @(negedge clk);
    desc_op = 2'd0; desc_index = NL'(40); desc_base = 64'h0; desc_size = 64'h1; desc_flags = 32'h0;
    desc_valid = 1'b1;
    for (int r = 0; r < 256; r++) begin
      n = 0;
      while (desc_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL err_sat_timeout: desc_ready stuck low at rejection %0d", r);
        break;
      end
      if (r == 255) begin
        checks++;
        if (err_count !== 8'd255) begin
          errors++; $display("FAIL err_count_255: err_count=%0d after 255 rejections, required 255", err_count);
        end
      end
      @(posedge clk);
      #1;
      if (r == 255) desc_valid = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (err_count !== 8'd255 || desc_err !== 1'b0 || rule_live !== exp_live) begin
      errors++; $display("FAIL err_saturate: err_count=%0d err=%b live=%h, required 255 0 %h", err_count, desc_err, rule_live, exp_live);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_reject();
    test_dsm_clear();
    test_clear_all();
    test_reset_mid();
    test_back_to_back();
    test_err_saturate();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_rule_loader.md
Name: addr_rule_loader

Overview:
- Config-side initiator for the address-range comparator's rule table. It takes one rule descriptor at a time over a valid/ready handshake.
- Each descriptor is turned into a sequence of single-cycle 64-bit cfg writes (base, size, flags, DSM base) on the comparator's cfg port.
- Rules are updated in an ordering that never creates a transient false match.
- Tracks which rules are live, and optionally sweeps the table clear after reset, because the comparator's table RAM is not reset.

Parameters:
- NUM_RULES, 32, number of comparator rules; must be <= 2^NUM_RULES_LOG2.
- NUM_RULES_LOG2, 5, width of the rule index.
- FLAG_WIDTH, 32, width of the rule flag field; must be <= 64.
- CFG_WIDTH, 10, cfg address width; 2^CFG_WIDTH must be >= 4*NUM_RULES.
- INIT_CLEAR, 1, 1 = run the clear-all sweep automatically after reset release.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  loader accepts a descriptor this cycle.
- desc_op  in  2  0=PROGRAM, 1=CLEAR_RULE, 2=SET_DSM, 3=CLEAR_ALL.
- desc_index  in  NUM_RULES_LOG2  rule number.
- desc_base  in  64  rule base address (PROGRAM) or DSM base (SET_DSM).
- desc_size  in  64  rule size in bytes.
- desc_flags  in  FLAG_WIDTH  rule flags.
- cfg_address  out  CFG_WIDTH  comparator word address.
- cfg_write  out  1  one-cycle write strobe.
- cfg_writedata  out  64  write data.
- cfg_byteenable  out  8  byte enables.
- rule_live  out  NUM_RULES  bit k = rule k currently programmed with nonzero size.
- busy  out  1  high whenever the FSM is not in IDLE.
- desc_err  out  1  one-cycle pulse when a descriptor is rejected.
- err_count  out  8  saturating count of rejected descriptors.

Behaviour:
- Address map:
  - base at index
  - size at NUM_RULES+index
  - flags at 2*NUM_RULES+index
  - DSM at 3*NUM_RULES
- All outputs are registered. Reset values:
  - desc_ready=0, cfg_write=0, cfg_address=0, cfg_writedata=0, cfg_byteenable=0
  - rule_live=0, busy=0, desc_err=0, err_count=0
- cfg_byteenable=8'hFF whenever cfg_write=1, and 0 otherwise.
- Flags are zero-extended to 64 bits.
- FSM states: INIT_SWEEP, IDLE, W_DIS, W_BASE, W_FLAGS, W_SIZE, SWEEP, ERR.
- After reset release:
  - INIT_CLEAR=1: enter INIT_SWEEP.
  - INIT_CLEAR=0: enter IDLE.
- desc_ready=1 only in IDLE. A handshake is desc_valid&desc_ready at a rising edge T; the descriptor fields are captured at that edge.
- PROGRAM, legal descriptor, desc_size!=0:
  - Writes in cycles T+1..T+4, in this order: size=0 (disable), base, flags, size.
  - rule_live[index] is set with the size write.
  - IDLE, with desc_ready=1, in cycle T+5.
  - Size is always written last, so the rule never matches with stale base or flags.
- PROGRAM with desc_size==0: behaves exactly as CLEAR_RULE.
- CLEAR_RULE:
  - One write, size=0, in cycle T+1.
  - rule_live[index] is cleared.
  - IDLE in cycle T+2.
- SET_DSM:
  - One write of desc_base to 3*NUM_RULES in cycle T+1.
  - IDLE in cycle T+2.
- CLEAR_ALL, and INIT_SWEEP:
  - A counter k runs 0..NUM_RULES-1 and writes size=0 at NUM_RULES+k, one write per cycle, NUM_RULES consecutive cycles.
  - rule_live is cleared on the final write.
  - Then IDLE.
  - Base and flags are not touched.
- Rejection rules:
  - PROGRAM is rejected if desc_index >= NUM_RULES, or if the 65-bit sum base+size >= 2^64 (carry out). This includes an end address of exactly 2^64, which would wrap to 0 in the comparator.
  - CLEAR_RULE is rejected if desc_index >= NUM_RULES.
  - On rejection: no cfg write, desc_err pulses in cycle T+1 (ERR state), err_count increments and saturates at 255, IDLE in cycle T+2.
- Exactly one cfg write per cycle at most. Writes within a sequence are back to back with no gaps.
- desc_* inputs are ignored while desc_ready=0.
- Reset asserted mid-sequence:
  - All outputs go to their reset values immediately; cfg_write drops asynchronously.
  - The partially programmed rule is left in the comparator. Its size was already written 0 by W_DIS, so it is disabled.
  - If INIT_CLEAR=1, the sweep reruns after reset release.

Test Plan:
- Reset release with INIT_CLEAR=1, NUM_RULES=32 -> busy=1 for 32 cycles; writes to addresses 32..63, data 0, byteenable FF; then desc_ready=1 and rule_live=0.
- PROGRAM index 3, base 0x1000, size 0x200, flags 0x5 -> writes (35,0), (3,0x1000), (67,0x5), (35,0x200) in cycles T+1..T+4; rule_live=0x8; desc_ready=1 at T+5.
- PROGRAM with base 0xFFFF_FFFF_FFFF_F000, size 0x1000 -> rejected: no cfg_write, desc_err pulse at T+1, err_count=1; same result for index 32 (NUM_RULES=32).
- SET_DSM base 0xABCD_0000 -> a single write (96, 0xABCD_0000) at T+1; then CLEAR_RULE index 3 -> write (35,0), rule_live bit 3 cleared.
- reset_n low during W_FLAGS -> cfg_write=0 in the same cycle, busy=0; after release a full sweep runs before desc_ready=1.
- desc_valid held high continuously with back-to-back PROGRAMs -> the second is accepted only at T+5, never while busy; 256 bad descriptors leave err_count=255.
